// File: rtl/deser_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : deser_arb_pkg
//  Description : Shared state encoding and width helpers for the deserializer
//                frame arbiter and its round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package deser_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PAD  = 2'd2
    } arb_state_t;

    // Width of a requester id; never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a word/stall counter; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : deser_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Search starts one past the
//                previous winner, so the last winner has lowest priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    gnt_any
);

    localparam int c_id_w = $clog2(NREQ);

    // One spare bit so last_grant + offset never overflows before the wrap
    logic [c_id_w:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest valid requester wins
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        w_idx   = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_idx = {1'b0, last_grant} + (c_id_w + 1)'(off);
            if (w_idx >= (c_id_w + 1)'(NREQ)) begin
                w_idx = w_idx - (c_id_w + 1)'(NREQ);
            end
            if (req[w_idx[c_id_w-1:0]]) begin
                gnt_id  = w_idx[c_id_w-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/deser_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : deser_frame_arbiter
//  Description : Grants one producer at a time for exactly DEPTH words into a
//                serial-to-parallel ping-pong buffer and tags each completed
//                frame with its source id.
//  Options     : FRAME_TIMEOUT_EN - pad a stalled frame with zero words after
//                TIMEOUT idle cycles and flag it with frame_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module deser_frame_arbiter
    import deser_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        buf_ena,
    output logic [WIDTH-1:0]            buf_data,
    input  logic                        buf_rdy,
    output logic                        frame_done,
    output logic [$clog2(NREQ)-1:0]     frame_src,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int              c_id_w      = id_width(NREQ);
    localparam int              c_cnt_w     = cnt_width(DEPTH);
    localparam logic [c_cnt_w-1:0] c_word_last = c_cnt_w'(DEPTH - 1);

    // Reject configurations the arbiter cannot serve
    if (NREQ < 2 || DEPTH < 1 || TIMEOUT < 1) begin : g_param_check
        $error("deser_frame_arbiter: need NREQ>=2, DEPTH>=1, TIMEOUT>=1");
    end

    arb_state_t          r_state;
    logic [c_id_w-1:0]   r_grant;
    logic [c_id_w-1:0]   r_last_grant;
    logic [c_cnt_w-1:0]  r_word_cnt;
    logic                r_frame_done;
    logic [c_id_w-1:0]   r_frame_src;
    logic [c_id_w-1:0]   w_pick_id;
    logic                w_pick_any;
    logic                w_last_word;

    rr_arbiter #(
        .NREQ       (NREQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .gnt_id     (w_pick_id),
        .gnt_any    (w_pick_any)
    );

    assign w_last_word = (r_word_cnt == c_word_last);
    assign busy        = (r_state != IDLE);
    assign frame_done  = r_frame_done;
    assign frame_src   = r_frame_src;

`ifdef FRAME_TIMEOUT_EN
    localparam int                  c_stall_w    = cnt_width(TIMEOUT);
    localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(TIMEOUT - 1);

    logic [c_stall_w-1:0] r_stall_cnt;
    logic                 r_frame_err;

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    // Route the granted producer to the buffer; PAD pushes zero words
    always_comb begin
        req_ready = '0;
        buf_ena   = 1'b0;
        buf_data  = '0;
        case (r_state)
            XFER: begin
                req_ready[r_grant] = buf_rdy;
                buf_ena            = req_valid[r_grant] & buf_rdy;
                buf_data           = req_data[r_grant];
            end
`ifdef FRAME_TIMEOUT_EN
            PAD: begin
                buf_ena = buf_rdy;
            end
`endif
            default: begin
            end
        endcase
    end

    // Grant FSM, word counting and registered frame tagging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= c_id_w'(NREQ - 1);
            r_word_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_frame_src  <= '0;
`ifdef FRAME_TIMEOUT_EN
            r_stall_cnt  <= '0;
            r_frame_err  <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            r_frame_err  <= 1'b0;
`endif
            // Every pushed word, real or padded, advances the frame
            if (buf_ena) begin
`ifdef FRAME_TIMEOUT_EN
                r_stall_cnt <= '0;
`endif
                if (w_last_word) begin
                    r_word_cnt   <= '0;
                    r_last_grant <= r_grant;
                    r_frame_done <= 1'b1;
                    r_frame_src  <= r_grant;
                    r_state      <= IDLE;
`ifdef FRAME_TIMEOUT_EN
                    r_frame_err  <= (r_state == PAD);
`endif
                end else begin
                    r_word_cnt <= r_word_cnt + c_cnt_w'(1);
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick_id;
                        r_state <= XFER;
`ifdef FRAME_TIMEOUT_EN
                        r_stall_cnt <= '0;
`endif
                    end
                end
`ifdef FRAME_TIMEOUT_EN
                XFER: begin
                    // Producer silent while the buffer could take a word
                    if (!buf_ena && buf_rdy) begin
                        if (r_stall_cnt == c_stall_last) begin
                            r_state <= PAD;
                        end else begin
                            r_stall_cnt <= r_stall_cnt + c_stall_w'(1);
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule : deser_frame_arbiter
`default_nettype wire

// File: tb/tb_deser_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deser_frame_arbiter
//  Description : Directed self-checking bench for deser_frame_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deser_frame_arbiter;

    localparam int NREQ    = 4;
    localparam int DEPTH   = 8;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       buf_ena;
    logic [WIDTH-1:0]           buf_data;
    logic                       buf_rdy;
    logic                       frame_done;
    logic [1:0]                 frame_src;
    logic                       frame_err;
    logic                       busy;

    deser_frame_arbiter #(
        .NREQ       (NREQ),
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .buf_ena    (buf_ena),
        .buf_data   (buf_data),
        .buf_rdy    (buf_rdy),
        .frame_done (frame_done),
        .frame_src  (frame_src),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               passes = 0;
    logic [WIDTH-1:0] base [NREQ];
    int               cnt  [NREQ];
    logic [WIDTH-1:0] pushed [$];
    logic [NREQ-1:0]  allow_mask;
    bit               other_ready;
    bit               done_seen;
    logic [1:0]       done_src;
    logic             done_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_data();
        for (int i = 0; i < NREQ; i++) req_data[i] = base[i] + WIDTH'(cnt[i]);
    endtask

    // One clock: observe the cycle's handshake, then move to the next negedge
    task automatic tick();
        #1;
        if (buf_ena) pushed.push_back(buf_data);
        if ((req_ready & ~allow_mask) != '0) other_ready = 1'b1;
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) cnt[i]++;
        @(negedge clk);
        set_data();
        done_seen = frame_done;
        done_src  = frame_src;
        done_err  = frame_err;
    endtask

    task automatic run_frame(output int cycles, output int words);
        int start;
        start  = pushed.size();
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!done_seen && cycles < 200);
        words = pushed.size() - start;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        set_data();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cyc, w, start, c_save;
        bit  ok;
        base[0] = 8'hA0; base[1] = 8'hC0; base[2] = 8'h10; base[3] = 8'hE0;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        allow_mask  = '1;
        other_ready = 1'b0;
        rst_n       = 1'b0;
        req_valid   = '1;
        buf_rdy     = 1'b1;
        set_data();

        // 1. reset with every requester valid
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_buf_ena",    buf_ena,    0);
        check("rst_req_ready",  req_ready,  0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy",       busy,       0);
        check("rst_frame_src",  frame_src,  0);
        check("rst_frame_err",  frame_err,  0);
        check("rst_buf_data",   buf_data,   0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_no_req_busy", busy, 0);

        // 2. single source: req 2 streams 0x10..0x17
        req_valid  = 4'b0100;
        allow_mask = 4'b0100;
        tick();
        check("t2_grant_busy", busy, 1);
        check("t2_no_done_yet", frame_done, 0);
        run_frame(cyc, w);
        check("t2_done_seen", done_seen, 1);
        check("t2_cycles", cyc, 8);
        check("t2_words", w, 8);
        check("t2_src", done_src, 2);
        check("t2_err", done_err, 0);
        for (int k = 0; k < DEPTH; k++)
            check($sformatf("t2_word%0d", k), pushed[k], 8'h10 + k);
        req_valid = '0;
        tick();
        check("t2_back_idle", busy, 0);
        check("t2_other_ready", other_ready, 0);

        // 3. all requesters valid: rotation 0,1,2,3,0
        do_reset();
        pushed.delete();
        req_valid  = '1;
        allow_mask = '1;
        for (int f = 0; f < 5; f++) begin
            start = pushed.size();
            run_frame(cyc, w);
            check($sformatf("t3_f%0d_done", f), done_seen, 1);
            check($sformatf("t3_f%0d_src", f), done_src, f % NREQ);
            check($sformatf("t3_f%0d_cycles", f), cyc, 9);
            check($sformatf("t3_f%0d_words", f), w, 8);
            ok = 1'b1;
            for (int k = 0; k < DEPTH; k++)
                if (start + k >= pushed.size() ||
                    pushed[start + k] !== base[f % NREQ] + WIDTH'((f / NREQ) * DEPTH + k))
                    ok = 1'b0;
            check($sformatf("t3_f%0d_data", f), ok, 1);
        end
        req_valid = '0;
        tick();

        // 4. bubbles and buffer stall mid-frame, req 3 competing
        req_valid   = 4'b1010;
        allow_mask  = 4'b0010;
        other_ready = 1'b0;
        c_save      = cnt[1];
        start       = pushed.size();
        tick();
        check("t4_grant_busy", busy, 1);
        repeat (3) tick();
        req_valid[1] = 1'b0;
        repeat (2) tick();
        req_valid[1] = 1'b1;
        buf_rdy      = 1'b0;
        #1;
        check("t4_stall_buf_ena", buf_ena, 0);
        check("t4_stall_ready", req_ready, 0);
        repeat (3) tick();
        buf_rdy = 1'b1;
        run_frame(cyc, w);
        check("t4_done", done_seen, 1);
        check("t4_src", done_src, 1);
        check("t4_words", pushed.size() - start, 8);
        check("t4_consumed", cnt[1] - c_save, 8);
        ok = 1'b1;
        for (int k = 0; k < DEPTH; k++)
            if (start + k >= pushed.size() || pushed[start + k] !== base[1] + WIDTH'(c_save + k))
                ok = 1'b0;
        check("t4_data", ok, 1);
        check("t4_other_ready", other_ready, 0);
        req_valid = '0;
        tick();

        // 5. reset pulse after word 5 of a req 0 frame
        req_valid  = 4'b0001;
        allow_mask = 4'b0001;
        start      = pushed.size();
        repeat (6) tick();
        check("t5_partial_words", pushed.size() - start, 5);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_buf_ena", buf_ena, 0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_done", frame_done, 0);
        check("t5_rst_src", frame_src, 0);
        tick();
        rst_n  = 1'b1;
        c_save = cnt[0];
        start  = pushed.size();
        run_frame(cyc, w);
        check("t5_done", done_seen, 1);
        check("t5_src", done_src, 0);
        check("t5_cycles", cyc, 9);
        check("t5_words", w, 8);
        ok = 1'b1;
        for (int k = 0; k < DEPTH; k++)
            if (start + k >= pushed.size() || pushed[start + k] !== base[0] + WIDTH'(c_save + k))
                ok = 1'b0;
        check("t5_data", ok, 1);
        req_valid = '0;
        tick();

`ifdef FRAME_TIMEOUT_EN
        // 6. req 1 stops after 3 words; frame padded with zeros
        do_reset();
        req_valid  = 4'b0010;
        allow_mask = 4'b0010;
        start      = pushed.size();
        repeat (4) tick();
        req_valid = '0;
        run_frame(cyc, w);
        check("t6_done", done_seen, 1);
        check("t6_err", done_err, 1);
        check("t6_src", done_src, 1);
        check("t6_cycles", cyc, 9);
        check("t6_words", pushed.size() - start, 8);
        ok = 1'b1;
        for (int k = 3; k < DEPTH; k++)
            if (start + k >= pushed.size() || pushed[start + k] !== 8'h00)
                ok = 1'b0;
        check("t6_pad_zero", ok, 1);
        tick();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_deser_frame_arbiter
`default_nettype wire
